// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered, flow-controlled immediate generator for decode.
// Extends instr[31:7] per immsrc, queues the result with its sideband tag in a
// 2-entry FIFO, and presents the head entry on a valid/ready output.
// Optional build macro: ZICSR_UIMM_EN (immsrc 101 = zero-extended CSR uimm).
// With the macro undefined, immsrc 101 is treated as unsupported.
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [1:0]       occupancy
);

    // in_instr[k] holds instruction bit k+7.
    logic            sgn;
    logic [XLEN-1:0] ext_imm;
    logic            ext_ill;

    logic [XLEN-1:0]  tail_imm;
    logic [TAG_W-1:0] tail_tag;
    logic             tail_ill;
    logic [1:0]       occ_q;
    logic [1:0]       occ_nxt;
    logic             rdy_q;
    logic             vld_q;
    logic             push;
    logic             pop;

    assign sgn = in_instr[24];

    // Combinational extension of the incoming instruction; illegal formats yield zero.
    always_comb begin
        ext_imm = '0;
        ext_ill = 1'b0;
        case (in_immsrc)
            3'b000: begin
                ext_imm        = {XLEN{sgn}};
                ext_imm[11:0]  = in_instr[24:13];
            end
            3'b001: begin
                ext_imm        = {XLEN{sgn}};
                ext_imm[11:0]  = {in_instr[24:18], in_instr[4:0]};
            end
            3'b010: begin
                ext_imm        = {XLEN{sgn}};
                ext_imm[12:0]  = {sgn, in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0};
            end
            3'b011: begin
                ext_imm        = {XLEN{sgn}};
                ext_imm[20:0]  = {sgn, in_instr[12:5], in_instr[13], in_instr[23:14], 1'b0};
            end
            3'b100: begin
                ext_imm        = {XLEN{sgn}};
                ext_imm[31:0]  = {in_instr[24:5], 12'b0};
            end
`ifdef ZICSR_UIMM_EN
            3'b101: begin
                ext_imm[4:0]   = in_instr[12:8];
            end
`endif
            default: begin
                ext_ill = 1'b1;
            end
        endcase
    end

    // Handshakes and next occupancy; full blocks push, empty blocks pop.
    always_comb begin
        push    = in_valid & rdy_q;
        pop     = vld_q & out_ready;
        occ_nxt = occ_q;
        if (push && !pop) begin
            occ_nxt = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_nxt = occ_q - 2'd1;
        end
    end

    // FIFO storage: the head lives directly in the output registers, the tail behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_imm     <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            tail_imm    <= '0;
            tail_tag    <= '0;
            tail_ill    <= 1'b0;
            occ_q       <= 2'd0;
            vld_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else if (flush) begin
            occ_q <= 2'd0;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        out_imm     <= ext_imm;
                        out_tag     <= in_tag;
                        out_illegal <= ext_ill;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_imm     <= ext_imm;
                        out_tag     <= in_tag;
                        out_illegal <= ext_ill;
                    end else if (push) begin
                        tail_imm <= ext_imm;
                        tail_tag <= in_tag;
                        tail_ill <= ext_ill;
                    end
                end
                default: begin
                    if (pop) begin
                        out_imm     <= tail_imm;
                        out_tag     <= tail_tag;
                        out_illegal <= tail_ill;
                    end
                end
            endcase
            occ_q <= occ_nxt;
            vld_q <= (occ_nxt != 2'd0);
            rdy_q <= (occ_nxt != 2'd2);
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances share all inputs.
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, in_valid, out_ready;
    logic [24:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [31:0] in_tag;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tag32;
    logic [1:0]  occ32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [1:0]  occ64;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] imm;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    imm_ext_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32),
        .occupancy(occ32)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64),
        .occupancy(occ64)
    );

    // Reference model built from the full 32-bit word with arithmetic shifts.
    function automatic exp_t model(input logic [24:0] ins, input logic [2:0] src, input logic [31:0] tag);
        logic [31:0]        w;
        logic signed [31:0] hi;
        logic [31:0]        u;
        logic [31:0]        v;
        logic               ext;
        exp_t               e;
        w     = {ins, 7'b0};
        e.tag = tag;
        e.ill = 1'b0;
        e.imm = '0;
        v     = '0;
        ext   = 1'b1;
        case (src)
            3'd0: begin hi = $signed(w) >>> 20; u = hi; v = u; end
            3'd1: begin hi = $signed(w) >>> 25; u = hi; v = (u << 5) | 32'(w[11:7]); end
            3'd2: begin
                hi = $signed(w) >>> 31; u = hi;
                v = (u << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            3'd3: begin
                hi = $signed(w) >>> 31; u = hi;
                v = (u << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            3'd4: v = w & 32'hFFFF_F000;
            3'd5: begin
                ext = 1'b0;
`ifdef ZICSR_UIMM_EN
                e.imm = 64'(w[19:15]);
`else
                e.ill = 1'b1;
`endif
            end
            default: begin ext = 1'b0; e.ill = 1'b1; end
        endcase
        if (ext) e.imm = {{32{v[31]}}, v};
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!reset_n || flush) begin
            sb.delete();
        end else begin
            if (vld32 && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_pop: got entry tag=%h but none expected", tag32);
                end else begin
                    mon_e = sb.pop_front();
                    if (imm32 !== mon_e.imm[31:0] || imm64 !== mon_e.imm || ill32 !== mon_e.ill ||
                        ill64 !== mon_e.ill || tag32 !== mon_e.tag || tag64 !== mon_e.tag || vld64 !== 1'b1) begin
                        n_err++;
                        $display("FAIL sb_entry: got imm32=%h imm64=%h ill=%b/%b tag=%h/%h, expected imm=%h ill=%b tag=%h",
                                 imm32, imm64, ill32, ill64, tag32, tag64, mon_e.imm, mon_e.ill, mon_e.tag);
                    end
                end
            end
            if (in_valid && rdy32) sb.push_back(model(in_instr, in_immsrc, in_tag));
        end
    end

    task automatic send(input logic [24:0] i, input logic [2:0] s, input logic [31:0] t);
        int n = 0;
        in_valid  = 1'b1;
        in_instr  = i;
        in_immsrc = s;
        in_tag    = t;
        @(negedge clk);
        while (!rdy32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", rdy32);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (occ32 != 2'd0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (occ32 !== 2'd0 || vld32 !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: occ=%0d valid=%b pending=%0d, expected 0/0/0", occ32, vld32, sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_immsrc = '0; in_tag = '0;
        #2;
        n_cmp++;
        if (rdy32 !== 1'b0 || vld32 !== 1'b0 || occ32 !== 2'd0 || imm32 !== '0 || tag32 !== '0 ||
            ill32 !== 1'b0 || imm64 !== '0 || rdy64 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b vld=%b occ=%0d imm=%h tag=%h ill=%b, expected all 0",
                     rdy32, vld32, occ32, imm32, tag32, ill32);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_cmp++;
        if (rdy32 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b expected 0", rdy32);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdy32 !== 1'b1 || occ32 !== 2'd0) begin
            n_err++;
            $display("FAIL ready_after_reset: rdy=%b occ=%0d expected 1/0", rdy32, occ32);
        end
    endtask

    task automatic test_i_type();
        out_ready = 1'b0;
        send({12'hFFF, 13'h0}, 3'd0, 32'h100);
        in_valid = 1'b0;
        n_cmp++;
        if (vld32 !== 1'b1 || imm32 !== 32'hFFFF_FFFF || ill32 !== 1'b0 || occ32 !== 2'd1) begin
            n_err++;
            $display("FAIL i_type: vld=%b imm=%h ill=%b occ=%0d expected 1/ffffffff/0/1", vld32, imm32, ill32, occ32);
        end
        drain();
    endtask

    task automatic test_u_b();
        out_ready = 1'b0;
        send({20'h80000, 5'h0}, 3'd4, 32'h200);
        in_valid = 1'b0;
        n_cmp++;
        if (imm64 !== 64'hFFFF_FFFF_8000_0000 || imm32 !== 32'h8000_0000 || ill64 !== 1'b0) begin
            n_err++;
            $display("FAIL u_type: imm64=%h imm32=%h expected ffffffff80000000/80000000", imm64, imm32);
        end
        drain();
        out_ready = 1'b0;
        send(25'h1, 3'd2, 32'h201);
        in_valid = 1'b0;
        n_cmp++;
        if (imm32 !== 32'h800 || imm64 !== 64'h800) begin
            n_err++;
            $display("FAIL b_type: imm32=%h imm64=%h expected 800", imm32, imm64);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(25'($urandom), 3'd0, 32'd1);
        send(25'($urandom), 3'd1, 32'd2);
        in_instr  = 25'($urandom);
        in_immsrc = 3'd3;
        in_tag    = 32'd3;
        @(negedge clk);
        n_cmp++;
        if (rdy32 !== 1'b0 || occ32 !== 2'd2) begin
            n_err++;
            $display("FAIL full: rdy=%b occ=%0d expected 0/2", rdy32, occ32);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (occ32 !== 2'd2 || vld32 !== 1'b1 || tag32 !== 32'd1) begin
            n_err++;
            $display("FAIL full_hold: occ=%0d vld=%b tag=%h expected 2/1/1", occ32, vld32, tag32);
        end
        out_ready = 1'b1;
        send(in_instr, in_immsrc, 32'd3);
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(25'($urandom), 3'($urandom_range(0, 7)), 32'h400);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_instr  = 25'($urandom);
            in_immsrc = 3'($urandom_range(0, 7));
            in_tag    = 32'h401 + 32'(i);
            @(negedge clk);
            n_cmp++;
            if (occ32 !== 2'd1 || rdy32 !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_occ[%0d]: occ=%0d rdy=%b expected 1/1", i, occ32, rdy32);
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(25'($urandom), 3'd0, 32'h500);
        send(25'($urandom), 3'd1, 32'h501);
        in_tag = 32'h502; out_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (occ32 !== 2'd0 || vld32 !== 1'b0 || rdy32 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full: occ=%0d vld=%b rdy=%b expected 0/0/1", occ32, vld32, rdy32);
        end
        out_ready = 1'b0;
        send(25'($urandom), 3'd2, 32'h510);
        in_tag = 32'h511; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (occ32 !== 2'd0 || vld32 !== 1'b0 || occ64 !== 2'd0) begin
            n_err++;
            $display("FAIL flush_drops_input: occ=%0d vld=%b expected 0/0", occ32, vld32);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(25'h1FF_FFFF, 3'd0, 32'h600);
        send(25'($urandom), 3'd4, 32'h601);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (vld32 !== 1'b0 || occ32 !== 2'd0 || imm32 !== '0 || tag32 !== '0 || ill32 !== 1'b0 ||
            rdy32 !== 1'b0 || imm64 !== '0 || vld64 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: vld=%b occ=%0d imm=%h tag=%h ill=%b rdy=%b expected all 0",
                     vld32, occ32, imm32, tag32, ill32, rdy32);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdy32 !== 1'b1 || occ32 !== 2'd0) begin
            n_err++;
            $display("FAIL ready_after_mid_reset: rdy=%b occ=%0d expected 1/0", rdy32, occ32);
        end
    endtask

    task automatic test_csr_illegal();
        out_ready = 1'b0;
        send(25'h1F00, 3'd5, 32'h700);
        in_valid = 1'b0;
        n_cmp++;
`ifdef ZICSR_UIMM_EN
        if (imm32 !== 32'h1F || ill32 !== 1'b0 || imm64 !== 64'h1F) begin
            n_err++;
            $display("FAIL csr_uimm: imm=%h ill=%b expected 1f/0", imm32, ill32);
        end
`else
        if (imm32 !== 32'h0 || ill32 !== 1'b1 || imm64 !== 64'h0) begin
            n_err++;
            $display("FAIL csr_uimm: imm=%h ill=%b expected 0/1", imm32, ill32);
        end
`endif
        drain();
        out_ready = 1'b0;
        send(25'h1FF_FFFF, 3'd7, 32'h701);
        in_valid = 1'b0;
        n_cmp++;
        if (ill32 !== 1'b1 || imm32 !== 32'h0 || ill64 !== 1'b1 || imm64 !== 64'h0) begin
            n_err++;
            $display("FAIL immsrc_111: imm=%h ill=%b expected 0/1", imm32, ill32);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_u_b();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_csr_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
